// File: rtl/vga_timing_pkg.sv
// 640x480@60 Hz raster constants shared by the timing generator and pixel-rate stages.
package vga_timing_pkg;

  localparam int unsigned CNT_W       = 10;
  localparam int unsigned CLK_DIV_DEF = 4;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_FP     = 16;
  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BP     = 48;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_FP     = 10;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BP     = 33;

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = H_ACTIVE + H_FP + H_SYNC - 1;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = V_ACTIVE + V_FP + V_SYNC - 1;

endpackage

// File: rtl/clk_en_div.sv
// Clock-enable divider: strobes once every CLK_DIV enabled clocks.
// o_tick_c is the same-cycle wrap strobe; o_pix_tick is its registered copy.
module clk_en_div #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  output logic o_tick_c,
  output logic o_pix_tick
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  if (CLK_DIV == 0) begin : g_bad_div
    $error("clk_en_div: CLK_DIV must be at least 1");
  end

  logic [DIV_W-1:0] r_div;
  logic             r_pix_tick;
  logic             w_wrap;

  assign w_wrap = i_en && (r_div == DIV_LAST);

  // Divider holds its phase while disabled so re-enabling adds no extra tick.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_div      <= '0;
      r_pix_tick <= 1'b0;
    end else begin
      r_pix_tick <= w_wrap;
      if (i_en) begin
        r_div <= w_wrap ? '0 : r_div + DIV_W'(1);
      end
    end
  end

  assign o_tick_c   = w_wrap;
  assign o_pix_tick = r_pix_tick;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel tick, h/v counters, sync, blanking and frame-start strobe.
// All decoded outputs are registered from next-state counters so they align with hcnt/vcnt.
module vga_timing_gen
  import vga_timing_pkg::CNT_W;
#(
  parameter int unsigned CLK_DIV  = vga_timing_pkg::CLK_DIV_DEF,
  parameter int unsigned H_ACTIVE = vga_timing_pkg::H_ACTIVE,
  parameter int unsigned H_FP     = vga_timing_pkg::H_FP,
  parameter int unsigned H_SYNC   = vga_timing_pkg::H_SYNC,
  parameter int unsigned H_BP     = vga_timing_pkg::H_BP,
  parameter int unsigned V_ACTIVE = vga_timing_pkg::V_ACTIVE,
  parameter int unsigned V_FP     = vga_timing_pkg::V_FP,
  parameter int unsigned V_SYNC   = vga_timing_pkg::V_SYNC,
  parameter int unsigned V_BP     = vga_timing_pkg::V_BP,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  output logic             o_pix_tick,
  output logic [CNT_W-1:0] o_hcnt,
  output logic [CNT_W-1:0] o_vcnt,
  output logic             o_hsync,
  output logic             o_vsync,
  output logic             o_video_on,
  output logic             o_frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT_L  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_L  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  if ((H_TOTAL > (1 << CNT_W)) || (V_TOTAL > (1 << CNT_W))) begin : g_bad_geom
    $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed the counter range");
  end

  logic             w_tick_c;
  logic [CNT_W-1:0] w_hnext;
  logic [CNT_W-1:0] w_vnext;
  logic             w_hs_on;
  logic             w_vs_on;

  logic [CNT_W-1:0] r_hcnt;
  logic [CNT_W-1:0] r_vcnt;
  logic             r_hsync;
  logic             r_vsync;
  logic             r_video_on;
  logic             r_frame_start;

  clk_en_div #(
    .CLK_DIV (CLK_DIV)
  ) u_div (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_en       (i_en),
    .o_tick_c   (w_tick_c),
    .o_pix_tick (o_pix_tick)
  );

  // Raster position after this edge; unchanged unless the divider wraps.
  always_comb begin
    w_hnext = r_hcnt;
    w_vnext = r_vcnt;
    if (w_tick_c) begin
      if (r_hcnt == H_LAST) begin
        w_hnext = '0;
        w_vnext = (r_vcnt == V_LAST) ? '0 : r_vcnt + CNT_W'(1);
      end else begin
        w_hnext = r_hcnt + CNT_W'(1);
      end
    end
  end

  assign w_hs_on = (w_hnext >= HS_FIRST) && (w_hnext <= HS_LAST);
  assign w_vs_on = (w_vnext >= VS_FIRST) && (w_vnext <= VS_LAST);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hcnt        <= '0;
      r_vcnt        <= '0;
      r_hsync       <= !SYNC_POL;
      r_vsync       <= !SYNC_POL;
      r_video_on    <= 1'b1;
      r_frame_start <= 1'b0;
    end else begin
      r_hcnt        <= w_hnext;
      r_vcnt        <= w_vnext;
      r_hsync       <= w_hs_on ? SYNC_POL : !SYNC_POL;
      r_vsync       <= w_vs_on ? SYNC_POL : !SYNC_POL;
      r_video_on    <= (w_hnext < H_ACT_L) && (w_vnext < V_ACT_L);
      // Only a counter wrap lands on (0,0) with a tick, so reset exit never strobes.
      r_frame_start <= w_tick_c && (w_hnext == '0) && (w_vnext == '0);
    end
  end

  assign o_hcnt        = r_hcnt;
  assign o_vcnt        = r_vcnt;
  assign o_hsync       = r_hsync;
  assign o_vsync       = r_vsync;
  assign o_video_on    = r_video_on;
  assign o_frame_start = r_frame_start;

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Generates 640x480@60 Hz VGA raster timing from the 100 MHz board clock. It produces a pixel tick, the horizontal and vertical pixel counters, and the sync and blanking signals. hcnt/vcnt feed the colour stages directly downstream, such as the solid-colour screen renderer. hsync/vsync go to the connector pins.

Parameters:
CLK_DIV, 4, board clocks per pixel (must be >= 1); 100 MHz / 4 = 25 MHz pixel rate
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch in pixels
H_SYNC, 96, hsync pulse width in pixels
H_BP, 48, horizontal back porch in pixels
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch in lines
V_SYNC, 2, vsync pulse width in lines
V_BP, 33, vertical back porch in lines
SYNC_POL, 0, active level of hsync/vsync (0 = active-low)

Ports:
clk  input  1  board clock, 100 MHz
rst  input  1  synchronous reset, active-high
en  input  1  run enable; when low, all counters hold
pix_tick  output  1  one-clk pulse marking the end of each pixel period
hcnt  output  10  horizontal pixel counter, 0..H_TOTAL-1
vcnt  output  10  vertical line counter, 0..V_TOTAL-1
hsync  output  1  horizontal sync
vsync  output  1  vertical sync
video_on  output  1  high while hcnt < H_ACTIVE and vcnt < V_ACTIVE
frame_start  output  1  one-clk pulse when the raster wraps to (0,0)

Behaviour:
- Derived constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800; V_TOTAL = 525. Both must be <= 1024; elaboration fails otherwise.
- Everything is clocked on the rising edge of clk. Reset is synchronous, active-high, and takes priority over en.
- Reset values: divider = 0, hcnt = 0, vcnt = 0, pix_tick = 0, hsync = vsync = !SYNC_POL, video_on = 1, frame_start = 0.
- Divider: counts 0..CLK_DIV-1 while en = 1.
  - pix_tick is registered. It is high for exactly one clk each time the divider wraps, i.e. CLK_DIV clocks after leaving reset, then every CLK_DIV clocks after that.
  - With CLK_DIV = 1, pix_tick is high on every enabled clk after reset.
- Counters advance only on a clk where pix_tick = 1 and en = 1:
  - hcnt increments; at H_TOTAL-1 it wraps to 0 and vcnt increments.
  - vcnt wraps V_TOTAL-1 -> 0 on the same edge that hcnt wraps.
  - The counters never reach H_TOTAL or V_TOTAL.
- hsync, vsync, video_on and frame_start are registered. They are computed from next-state counter values so they are valid in the same cycle as the hcnt/vcnt they describe, with zero relative skew.
  - hsync = SYNC_POL when hcnt is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] = [656, 751].
  - vsync = SYNC_POL when vcnt is in [490, 491].
  - frame_start is high for exactly one clk, the first clk on which (hcnt, vcnt) = (0, 0) after a wrap. It is not asserted on leaving reset.
- en low: divider, counters and sync outputs hold their values, and pix_tick = 0. On en rising, the divider resumes from its held value, so no extra tick is generated.
- Reset mid-frame: on the next edge all state returns to reset values and the raster restarts at (0,0). The partial frame is discarded.
- Overall latency: hcnt changes on the same edge that pix_tick rises, so hcnt/vcnt may be sampled by downstream stages on any clk. The colour stage sees a stable value for CLK_DIV clocks.

Decomposition:
- Package vga_timing_pkg holds:
  - the 640x480 timing constants (active, porch and sync widths);
  - the derived H_TOTAL, V_TOTAL, HS_START, HS_END, VS_START, VS_END;
  - the counter width constant CNT_W = 10.
- One sub-module, clk_en_div, holds the parameterised CLK_DIV divider producing pix_tick. It takes clk, rst and en, and is reusable by other pixel-rate stages.
- The raster counters and sync decode live in the top level.

Test Plan:
- Reset: hold rst for 3 clk, then release -> all outputs at their reset values. First pix_tick occurs on clk 4 after release, and hcnt = 1 on that edge.
- Line timing: run one line -> hsync low exactly while hcnt is 656..751 (96 pixels = 384 clk). video_on drops at hcnt = 640. hcnt wraps 799 -> 0 with vcnt 0 -> 1.
- Frame timing: run a full frame -> vsync low for vcnt 490..491 (1600 pixels). At (799, 524) -> (0, 0), frame_start pulses once for 1 clk. Frame period = 420000 pixels = 1680000 clk.
- Enable hold: drop en for 37 clk at hcnt = 100 -> hcnt, vcnt, hsync and the divider all frozen, no pix_tick. After en returns, the pix_tick spacing continues from the held divider phase.
- Reset mid-frame: assert rst at (hcnt, vcnt) = (700, 300) -> on the next edge (0, 0), hsync/vsync inactive, and no frame_start pulse.
- CLK_DIV = 1 instance: hcnt increments every clk, and the line period is exactly 800 clk.
